fpga_mem_responder: RTL and testbench
=====================================

Name: fpga_mem_responder

Overview:
- Memory-side end of the split address/data bus between the cache-side memory controller and FPGA memory.
- Decodes address, read and write beats from the c_to_m signal group and drives data and resp on the m_to_c group.
- Backs each request with an internal word-addressed synchronous SRAM.
- Runs entirely in the clk domain; any clock crossing sits upstream.

Parameters:
MEM_WORDS, 4096, depth of backing SRAM in 32-bit words (power of two).
HOLDOFF, 4, idle cycles after every resp pulse before the next beat is sampled; covers upstream crossing latency.
BURST_LEN, 8, 32-bit beats per burst (fixed, 256-bit line).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
address_data_bus_c_to_m  in  32  address on address beats, write data on data beats
address_on_c_to_m  in  1  marks an address beat
data_on_c_to_m  in  1  marks a data beat
read_en_c_to_m  in  1  read command qualifier
write_en_c_to_m  in  1  write command qualifier
address_data_bus_m_to_c  out  32  read data
resp_m_to_c  out  1  one-cycle ack / read-data-valid pulse
err  out  1  sticky range error (see Optional Feature)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - resp_m_to_c=0, address_data_bus_m_to_c=0, err=0.
  - State goes to IDLE; beat and holdoff counters are zeroed.
  - SRAM contents are not cleared.
  - Reset mid-burst aborts the burst; words already written stay written.
- Beat decode: inputs are sampled only in IDLE, W_DATA and W_DONE, and only when holdoff is 0.
  - Read address beat: address_on=1, read_en=1, write_en=0.
  - Write address beat: address_on=1, write_en=1, read_en=0.
  - Write data beat: address_on=0, data_on=1, write_en=1.
  - read_en and write_en both set: no-op, no resp.
- Addressing: base word index = addr[31:5]*8, taken modulo MEM_WORDS.
  - addr[4:0] is ignored (bursts are line-aligned).
  - Beat k accesses word base+k.
- State machine: IDLE, W_DATA, W_DONE, R_FETCH, R_STREAM, HOLD.
  - IDLE + write address beat at cycle T:
    - Latch base address.
    - resp=1 at T+1, then HOLD for HOLDOFF cycles, then W_DATA with beat=0.
  - W_DATA + data beat at T:
    - SRAM[base+beat] written with bus data.
    - resp=1 at T+1, beat increments, then HOLD.
    - After beat 7, go to W_DONE (via HOLD).
  - W_DONE + data beat at T:
    - Commit ack: resp=1 at T+1, no SRAM write.
    - HOLD, then IDLE.
  - IDLE + read address beat at T: R_FETCH issues the SRAM read for beat 0.
    - Word k appears on the bus with resp=1 at T+2+k, for k=0..7: back-to-back, no gaps, no backpressure.
    - Then HOLD, then IDLE.
  - Address beat received in W_DATA or W_DONE aborts the current write and is decoded as a fresh command.
  - All inputs are ignored in R_FETCH, R_STREAM and HOLD.
- Outputs:
  - resp is exactly one cycle per event.
  - address_data_bus_m_to_c holds its last value when resp=0.
- Totals: a write costs 10 resp pulses (1 address + 8 data + 1 commit); a read costs 8.

Optional Feature:
- Macro: FPGA_MEM_RANGE_CHECK_EN.
- Defined:
  - A base address with addr[31:5]*8 >= MEM_WORDS is out of range; it does not wrap.
  - Out-of-range write: all 10 resps still issue, SRAM is untouched, err is set.
  - Out-of-range read: streams 8 words of 32'hDEADBEEF, err is set.
  - err clears only on rst.
- Undefined: addresses wrap modulo MEM_WORDS and err is tied 0.

Test Plan:
- Write addr 0x00000040, then data beats 0x11111111..0x88888888 with commit beat -> 10 resp pulses, each followed by HOLDOFF idle cycles. SRAM words 16..23 hold those values; word 15 and word 24 are unchanged.
- Read addr 0x00000040 after the above -> resp high for 8 consecutive cycles starting T+2; data 0x11111111..0x88888888 in order; no resp during HOLD.
- Read addr 0x00000047 (misaligned) -> identical stream to addr 0x40.
- Write address beat, 3 data beats, then read address beat at 0x80 -> write aborted. Words 16..18 are updated and 19..23 unchanged. Read of 0x80 streams normally.
- rst asserted on the 4th cycle of a read stream -> resp=0, bus=0 the next cycle. Later read address beat at 0x40 is serviced from IDLE.
- With FPGA_MEM_RANGE_CHECK_EN and MEM_WORDS=4096: read addr 0x00008000 -> 8× 0xDEADBEEF, err=1 sticky. Same test without the macro -> words 0..7 returned, err=0.

Source files
------------

// File: rtl/fpga_mem_responder_if.sv
// rtl/fpga_mem_responder_if.sv - c_to_m / m_to_c signal groups between cache-side controller and FPGA memory
interface fpga_mem_responder_if;
  logic [31:0] address_data_bus_c_to_m;
  logic        address_on_c_to_m;
  logic        data_on_c_to_m;
  logic        read_en_c_to_m;
  logic        write_en_c_to_m;
  logic [31:0] address_data_bus_m_to_c;
  logic        resp_m_to_c;
  logic        err;

  modport master (
    output address_data_bus_c_to_m, address_on_c_to_m, data_on_c_to_m,
           read_en_c_to_m, write_en_c_to_m,
    input  address_data_bus_m_to_c, resp_m_to_c, err
  );

  modport slave (
    input  address_data_bus_c_to_m, address_on_c_to_m, data_on_c_to_m,
           read_en_c_to_m, write_en_c_to_m,
    output address_data_bus_m_to_c, resp_m_to_c, err
  );
endinterface

// File: rtl/fpga_mem_responder.sv
// rtl/fpga_mem_responder.sv - memory-side burst responder backed by a word-addressed synchronous SRAM
// Optional out-of-range detection is enabled by defining FPGA_MEM_RANGE_CHECK_EN.
module fpga_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int HOLDOFF   = 4,
  parameter int BURST_LEN = 8
) (
  input logic                 clk,
  input logic                 rst,
  fpga_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 3;
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_DONE, R_FETCH, R_STREAM, HOLD
  } state_t;

  state_t        state;
  state_t        hold_next;
  logic [2:0]    beat;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] line;
  logic          oor;
  logic          resp_q;
  logic [31:0]   rd_q;
  logic [31:0]   mem [MEM_WORDS];

  logic [31:0]   addr;
  logic [LW-1:0] addr_line;
  logic          addr_oor;
  logic          sample;
  logic          rd_addr_beat;
  logic          wr_addr_beat;
  logic          data_beat;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic          unused_bits;

  assign addr        = bus.address_data_bus_c_to_m;
  assign addr_line   = addr[LW+4:5];
  assign unused_bits = ^{addr[4:0], addr[31:LW+5]};

`ifdef FPGA_MEM_RANGE_CHECK_EN
  assign addr_oor = |addr[31:LW+5];
`else
  assign addr_oor = 1'b0;
`endif

  // Holdoff is folded into the HOLD state, so these states always see a zero holdoff.
  assign sample       = (state == IDLE) || (state == W_DATA) || (state == W_DONE);
  assign rd_addr_beat = sample && bus.address_on_c_to_m && bus.read_en_c_to_m && !bus.write_en_c_to_m;
  assign wr_addr_beat = sample && bus.address_on_c_to_m && bus.write_en_c_to_m && !bus.read_en_c_to_m;
  assign data_beat    = sample && !bus.address_on_c_to_m && bus.data_on_c_to_m &&
                        bus.write_en_c_to_m && !bus.read_en_c_to_m;

  assign mem_we   = !rst && (state == W_DATA) && data_beat && !oor;
  assign mem_re   = (state == R_FETCH) || (state == R_STREAM);
  assign mem_addr = {line, beat};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_next <= IDLE;
      beat      <= '0;
      hold_cnt  <= '0;
      line      <= '0;
      oor       <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE, W_DATA, W_DONE: begin
          if (rd_addr_beat) begin
            line  <= addr_line;
            oor   <= addr_oor;
            beat  <= '0;
            state <= R_FETCH;
          end else if (wr_addr_beat) begin
            line      <= addr_line;
            oor       <= addr_oor;
            beat      <= '0;
            resp_q    <= 1'b1;
            hold_next <= W_DATA;
            hold_cnt  <= HW'(HOLDOFF);
            state     <= HOLD;
          end else if (data_beat && state == W_DATA) begin
            resp_q    <= 1'b1;
            beat      <= beat + 3'd1;
            hold_next <= (beat == LAST_BEAT) ? W_DONE : W_DATA;
            hold_cnt  <= HW'(HOLDOFF);
            state     <= HOLD;
          end else if (data_beat && state == W_DONE) begin
            resp_q    <= 1'b1;
            hold_next <= IDLE;
            hold_cnt  <= HW'(HOLDOFF);
            state     <= HOLD;
          end
        end
        R_FETCH: begin
          resp_q <= 1'b1;
          beat   <= beat + 3'd1;
          state  <= R_STREAM;
        end
        R_STREAM: begin
          resp_q <= 1'b1;
          beat   <= beat + 3'd1;
          if (beat == LAST_BEAT) begin
            hold_next <= IDLE;
            hold_cnt  <= HW'(HOLDOFF);
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= hold_next;
          else hold_cnt <= hold_cnt - HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= addr;
  end

  // The SRAM output register doubles as the bus register, so it holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else if (mem_re) rd_q <= oor ? 32'hDEADBEEF : mem[mem_addr];
  end

`ifdef FPGA_MEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((rd_addr_beat || wr_addr_beat) && addr_oor) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.resp_m_to_c             = resp_q;
  assign bus.address_data_bus_m_to_c = rd_q;
endmodule

// File: tb/tb_fpga_mem_responder.sv
// tb/tb_fpga_mem_responder.sv - self-checking bench for fpga_mem_responder
module tb_fpga_mem_responder;
  localparam int MEM_WORDS = 4096;
  localparam int HOLDOFF   = 4;
  localparam int BURST_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  int   next_ok = 0;

  bit          exp_resp    [int];
  logic [31:0] exp_data    [int];
  bit          exp_err_set [int];
  bit          exp_clear   [int];
  logic [31:0] mem_m       [int];
  int          cur_base;
  bit          cur_oor;
  int          cur_beats;

  fpga_mem_responder_if bus ();

  fpga_mem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .HOLDOFF  (HOLDOFF),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: stuck at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %08h, required %08h", name, cyc, act, exp);
    end
  endfunction

  function automatic int line_base(input logic [31:0] a);
    longint idx;
    idx = longint'(a >> 5) * 8;
    return int'(idx % MEM_WORDS);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef FPGA_MEM_RANGE_CHECK_EN
    return (longint'(a >> 5) * 8) >= MEM_WORDS;
`else
    return (a === 32'hx);
`endif
  endfunction

  // Per-cycle comparison against the transaction schedule built by the stimulus tasks.
  initial begin
    logic [31:0] m_data;
    bit          m_err;
    m_data = '0;
    m_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_clear.exists(cyc)) begin
          m_data = '0;
          m_err  = 1'b0;
        end
        if (exp_err_set.exists(cyc)) m_err = 1'b1;
        if (exp_data.exists(cyc)) m_data = exp_data[cyc];
        check("resp", 32'(bus.resp_m_to_c), 32'(exp_resp.exists(cyc)));
        check("rdata", bus.address_data_bus_m_to_c, m_data);
        check("err", 32'(bus.err), 32'(m_err));
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit a, input bit d, input bit r, input bit w, input logic [31:0] v);
    bus.address_on_c_to_m       = a;
    bus.data_on_c_to_m          = d;
    bus.read_en_c_to_m          = r;
    bus.write_en_c_to_m         = w;
    bus.address_data_bus_c_to_m = v;
    @(posedge clk);
    #1;
    bus.address_on_c_to_m = 1'b0;
    bus.data_on_c_to_m    = 1'b0;
    bus.read_en_c_to_m    = 1'b0;
    bus.write_en_c_to_m   = 1'b0;
  endtask

  task automatic wr_addr(input logic [31:0] a);
    int t;
    wait_cyc(next_ok);
    t = cyc;
    cur_base  = line_base(a);
    cur_oor   = out_of_range(a);
    cur_beats = 0;
    exp_resp[t+1] = 1'b1;
    if (cur_oor) exp_err_set[t+1] = 1'b1;
    next_ok = t + 2 + HOLDOFF;
    drive(1'b1, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic wr_data(input logic [31:0] v);
    int t;
    wait_cyc(next_ok);
    t = cyc;
    exp_resp[t+1] = 1'b1;
    if (cur_beats < BURST_LEN && !cur_oor) mem_m[cur_base + cur_beats] = v;
    cur_beats++;
    next_ok = t + 2 + HOLDOFF;
    drive(1'b0, 1'b1, 1'b0, 1'b1, v);
  endtask

  task automatic rd_addr(input logic [31:0] a, output int t);
    int base;
    bit o;
    wait_cyc(next_ok);
    t    = cyc;
    base = line_base(a);
    o    = out_of_range(a);
    if (o) exp_err_set[t+1] = 1'b1;
    for (int k = 0; k < BURST_LEN; k++) begin
      exp_resp[t+2+k] = 1'b1;
      exp_data[t+2+k] = o ? 32'hDEADBEEF : mem_m[base + k];
    end
    next_ok = t + 2 + BURST_LEN + HOLDOFF;
    drive(1'b1, 1'b0, 1'b1, 1'b0, a);
  endtask

  task automatic write_line(input logic [31:0] a, input logic [31:0] first, input logic [31:0] step);
    wr_addr(a);
    for (int k = 0; k < BURST_LEN; k++) wr_data(first + step * k);
    wr_data(32'hC0AA17ED);
  endtask

  initial begin
    int t;
    int keys[$];
    bus.address_on_c_to_m       = 1'b0;
    bus.data_on_c_to_m          = 1'b0;
    bus.read_en_c_to_m          = 1'b0;
    bus.write_en_c_to_m         = 1'b0;
    bus.address_data_bus_c_to_m = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_resp", 32'(bus.resp_m_to_c), 32'd0);
    check("reset_rdata", bus.address_data_bus_m_to_c, 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    next_ok = cyc;
    chk_en  = 1'b1;

    // Known contents around the lines under test.
    write_line(32'h0000_0000, 32'hC000_0000, 32'd1);
    write_line(32'h0000_0020, 32'hA000_0000, 32'd1);
    write_line(32'h0000_0060, 32'hB000_0000, 32'd1);
    write_line(32'h0000_0080, 32'hE000_0000, 32'd1);

    write_line(32'h0000_0040, 32'h1111_1111, 32'h1111_1111);

    // Conflicting qualifiers, and a data beat outside a write: both are no-ops.
    wait_cyc(next_ok);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    next_ok = cyc;

    rd_addr(32'h0000_0020, t);
    rd_addr(32'h0000_0060, t);

    rd_addr(32'h0000_0040, t);
    wait_cyc(t + 2);
    #2;
    check("lit_first_word", bus.address_data_bus_m_to_c, 32'h1111_1111);
    check("lit_first_resp", 32'(bus.resp_m_to_c), 32'd1);
    wait_cyc(t + 9);
    #2;
    check("lit_last_word", bus.address_data_bus_m_to_c, 32'h8888_8888);
    wait_cyc(t + 10);
    #2;
    check("lit_hold_resp", 32'(bus.resp_m_to_c), 32'd0);

    // Misaligned address, with a stray write address beat mid-stream that must be ignored.
    rd_addr(32'h0000_0047, t);
    wait_cyc(t + 4);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);

    // Write aborted after three beats by a read address beat.
    wr_addr(32'h0000_0040);
    for (int k = 0; k < 3; k++) wr_data(32'hD000_0000 + k);
    rd_addr(32'h0000_0080, t);
    rd_addr(32'h0000_0040, t);
    wait_cyc(t + 4);
    #2;
    check("lit_abort_word18", bus.address_data_bus_m_to_c, 32'hD000_0002);
    wait_cyc(t + 5);
    #2;
    check("lit_abort_word19", bus.address_data_bus_m_to_c, 32'h4444_4444);

    // Reset on the fourth beat of a read stream.
    rd_addr(32'h0000_0040, t);
    wait_cyc(t + 5);
    rst = 1'b1;
    foreach (exp_resp[k]) if (k > t + 5) keys.push_back(k);
    foreach (keys[i]) begin
      exp_resp.delete(keys[i]);
      exp_data.delete(keys[i]);
    end
    exp_clear[t+6] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("lit_rst_resp", 32'(bus.resp_m_to_c), 32'd0);
    check("lit_rst_rdata", bus.address_data_bus_m_to_c, 32'd0);
    next_ok = cyc;
    rd_addr(32'h0000_0040, t);

    // Address beyond the SRAM: error stream or wrap depending on the build.
    rd_addr(32'h0000_8000, t);
    wait_cyc(t + 2);
    #2;
`ifdef FPGA_MEM_RANGE_CHECK_EN
    check("lit_oor_word", bus.address_data_bus_m_to_c, 32'hDEADBEEF);
    check("lit_oor_err", 32'(bus.err), 32'd1);
`else
    check("lit_wrap_word", bus.address_data_bus_m_to_c, 32'hC000_0000);
    check("lit_wrap_err", 32'(bus.err), 32'd0);
`endif
    wait_cyc(next_ok + 4);
    #2;
`ifdef FPGA_MEM_RANGE_CHECK_EN
    check("lit_err_sticky", 32'(bus.err), 32'd1);
`else
    check("lit_err_tied", 32'(bus.err), 32'd0);
`endif

    wait_cyc(next_ok + 6);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
